// File: rtl/return_target_checker_if.sv
// Return-prediction handshake bundle.
// Fetch pushes predictions; execute resolves them.
interface return_target_checker_if;
  logic        pred_valid;
  logic [31:0] pred_target;
  logic        pred_ready;
  logic        res_valid;
  logic [31:0] res_target;
  logic        res_ready;

  modport master (
    output pred_valid, pred_target,
    output res_valid, res_target,
    input  pred_ready, res_ready
  );

  modport slave (
    input  pred_valid, pred_target,
    input  res_valid, res_target,
    output pred_ready, res_ready
  );
endinterface

// File: rtl/return_target_checker.sv
// Checks RAS-predicted return targets against resolved ones.
// A mismatch flushes the in-flight queue and redirects fetch.
module return_target_checker #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  return_target_checker_if.slave bus,
  input  logic                   flush,
  output logic                   mispredict,
  output logic [31:0]            redirect_pc,
  output logic [PTR_W:0]         occupancy,
  output logic [15:0]            hit_count,
  output logic [15:0]            miss_count
);

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);
  localparam logic [15:0]    SAT  = 16'hFFFF;

  logic [31:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   occ_q, occ_d;
  logic             mis_q, mis_d;
  logic [31:0]      redir_q, redir_d;
  logic [15:0]      hit_q, hit_d;
  logic [15:0]      miss_q, miss_d;
  logic             wr_en;
  logic             push_en;
  logic             pop_en;
  logic             match;

  assign bus.pred_ready = (occ_q < FULL);
  assign bus.res_ready  = (occ_q != '0);
  assign push_en = bus.pred_valid & bus.pred_ready;
  assign pop_en  = bus.res_valid & bus.res_ready;
  assign match   = (mem_q[rd_ptr_q] == bus.res_target);

  assign mispredict  = mis_q;
  assign redirect_pc = redir_q;
  assign occupancy   = occ_q;
  assign hit_count   = hit_q;
  assign miss_count  = miss_q;

  // Next-state: flush beats a mismatch, which beats push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    mis_d    = 1'b0;
    redir_d  = redir_q;
    hit_d    = hit_q;
    miss_d   = miss_q;
    wr_en    = 1'b0;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else if (pop_en && !match) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
      mis_d    = 1'b1;
      redir_d  = bus.res_target;
      if (miss_q != SAT) miss_d = miss_q + 16'd1;
    end else begin
      if (push_en) begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop_en) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (hit_q != SAT) hit_d = hit_q + 16'd1;
      end
      if (push_en && !pop_en) occ_d = occ_q + 1'b1;
      else if (!push_en && pop_en) occ_d = occ_q - 1'b1;
    end
  end

  // Control and statistics registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      mis_q    <= 1'b0;
      redir_q  <= 32'h0;
      hit_q    <= '0;
      miss_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      mis_q    <= mis_d;
      redir_q  <= redir_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
    end
  end

  // Prediction storage; stale entries are never read.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= bus.pred_target;
  end

endmodule

// File: doc/return_target_checker.md
RETURN_TARGET_CHECKER -- requirements
Module: return_target_checker

Interface
REQ-001 SHALL have parameter DEPTH, default 8, in-flight predicted-return queue entries (power of two, 2..8).
REQ-002 SHALL have parameter PTR_W, default 3, queue pointer width, equal to log2(DEPTH).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous active-high reset.
REQ-005 SHALL have port pred_valid  input  1  fetch issued a return using a stack-predicted target.
REQ-006 SHALL have port pred_target  input  32  predicted return target from the return address stack.
REQ-007 SHALL have port pred_ready  output  1  queue can accept a prediction (not full).
REQ-008 SHALL have port res_valid  input  1  execute resolved the oldest outstanding return.
REQ-009 SHALL have port res_target  input  32  actual computed return target.
REQ-010 SHALL have port res_ready  output  1  queue holds at least one prediction (not empty).
REQ-011 SHALL have port flush  input  1  pipeline flush from elsewhere; discards all outstanding predictions.
REQ-012 SHALL have port mispredict  output  1  registered one-cycle pulse: resolved target differed from prediction.
REQ-013 SHALL have port redirect_pc  output  32  registered correct target, valid while mispredict=1.
REQ-014 SHALL have port occupancy  output  PTR_W+1  number of queued predictions.
REQ-015 SHALL have port hit_count  output  16  saturating count of correct return predictions.
REQ-016 SHALL have port miss_count  output  16  saturating count of return mispredictions.

Function
REQ-017 SHALL be a circular FIFO of DEPTH x 32-bit entries with write pointer, read pointer (PTR_W bits, wrap DEPTH-1 -> 0) and occupancy counter.
REQ-018 SHALL assert pred_ready combinationally iff occupancy < DEPTH; res_ready iff occupancy > 0.
REQ-019 SHALL push pred_target at write pointer when pred_valid & pred_ready; pred_valid while full is ignored, no state change.
REQ-020 SHALL pop oldest entry when res_valid & res_ready; res_valid while empty is ignored, no counter change, no mispredict.
REQ-021 SHALL on pop compare full 32 bits: equal -> hit_count+1, mispredict<=0; unequal -> miss_count+1, mispredict<=1, redirect_pc<=res_target.
REQ-022 SHALL on a mismatching pop also clear the queue (pointers and occupancy to 0) at the same edge; any same-cycle push is dropped (wrong path).
REQ-023 SHALL on matching pop with simultaneous push update both pointers and leave occupancy unchanged; push while full is not enabled by a same-cycle pop.
REQ-024 SHALL give flush priority over push and pop: pointers/occupancy to 0, mispredict<=0, counters and redirect_pc unchanged, same-cycle resolution not counted.
REQ-025 SHALL hold mispredict high exactly one cycle per mismatch; back-to-back mismatches impossible since queue empties.
REQ-026 SHALL saturate hit_count and miss_count at 16'hFFFF (no wrap).
REQ-027 SHALL produce latency of one cycle from resolving pop to mispredict/redirect_pc.
REQ-028 SHALL not reset queue entry storage; contents are don't-care when not counted in occupancy.

Reset
REQ-029 SHALL on reset asserted asynchronously force pointers, occupancy, mispredict, hit_count, miss_count to 0 and redirect_pc to 32'h0, including mid-operation.
REQ-030 SHALL present pred_ready=1, res_ready=0 while reset is asserted and on the first edge after release.

Verification
REQ-031 SHALL cover push 0x00400010, 0x00400020; resolve 0x00400010 -> hit_count=1, mispredict=0, occupancy=1.
REQ-032 SHALL cover push 0x00400010, 0x00400020; resolve 0x00400014 -> next cycle mispredict=1, redirect_pc=0x00400014, occupancy=0, miss_count=1.
REQ-033 SHALL cover 8 pushes -> pred_ready=0; 9th push ignored; 8 matching resolves return targets in push order, pointer wrap checked by 8 more push/resolve pairs.
REQ-034 SHALL cover flush asserted together with push and mismatching resolve -> occupancy=0, mispredict=0, counters unchanged.
REQ-035 SHALL cover res_valid while empty -> no counter change, mispredict=0; reset asserted with occupancy=5 -> immediate occupancy=0, counters 0.
REQ-036 SHALL cover hit_count preloaded by 65535 hits then one more hit -> hit_count stays 16'hFFFF.
